delay_tap_crossfade_mixer: RTL
==============================

# delay_tap_crossfade_mixer

Downstream consumer of the multi-tap delay lines: takes the four 8-bit delayed taps plus the undelayed (dry) sample and produces a weighted, saturated echo mix. Tap changes never switch abruptly. A per-sample gain-ramp FSM fades the wet path to zero, swaps taps, then fades back in. The block sits between the delay-line bank and the top-level output mux and replaces the hard tap select.

## Interface
- `W`, 8, sample width (unsigned)
- `GAIN_W`, 4, gain width; gains are fractions g/16
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  one new sample on `dry`/`taps` this cycle
- `dry`  in  W  undelayed input sample
- `taps`  in  4*W  tap k (30/45/60/90 delay) at bits [8k+7:8k]
- `tap_sel`  in  2  requested wet tap, sampled on in_valid cycles only
- `dry_gain`  in  GAIN_W  dry weight, applied directly
- `wet_gain`  in  GAIN_W  target wet weight, reached by ramping
- `mix_out`  out  W  mixed sample
- `out_valid`  out  1  mix_out updated this cycle
- `fading`  out  1  FSM not in IDLE
- `active_tap`  out  2  tap currently feeding the wet path

## Operation
- Registers: state {IDLE, FADE_OUT, FADE_IN}, cur_gain[GAIN_W], active_tap[2], stage-1 products + valid, stage-2 output.
- Every computation and FSM step occurs only on in_valid cycles. A sample always uses the pre-update cur_gain and active_tap.
- Arithmetic: pd = dry*dry_gain (12b), pw = taps[active_tap]*cur_gain (12b), sum = pd+pw (13b), mix = sum>>4, saturate to 255 if mix > 255. No rounding (truncate).
- IDLE
  - If tap_sel != active_tap: go to FADE_OUT, cur_gain unchanged.
  - Else: step cur_gain by ±1 toward wet_gain, hold when equal. This gives soft start after reset and smooths gain edits.
- FADE_OUT
  - If cur_gain == 0: active_tap <= tap_sel (value at this cycle), go to FADE_IN.
  - Else: cur_gain -= 1. tap_sel changes during FADE_OUT are absorbed, because the latest value is taken at the swap.
- FADE_IN
  - If tap_sel != active_tap: go to FADE_OUT (restart fade from the current gain).
  - Else if cur_gain == wet_gain: go to IDLE.
  - Else: step cur_gain ±1 toward wet_gain (down if wet_gain was lowered mid-fade).
- fading = (state != IDLE). active_tap and fading are registered outputs.
- cur_gain never wraps: decrement is blocked at 0, and increment never exceeds wet_gain ≤ 15.

## Timing
- Latency: sample accepted at cycle N → mix_out/out_valid at cycle N+2. Throughput is 1 sample/cycle.
- out_valid is a 1-cycle pulse per accepted sample. Back-to-back in_valid gives back-to-back out_valid.
- mix_out holds its last value when out_valid=0. In-flight bubbles are not emitted.
- FSM and cur_gain update at the same edge that captures stage 1 for that sample.
- Reset (any cycle, including mid-fade or with samples in flight):
  - Next cycle: state=IDLE, cur_gain=0, active_tap=0, fading=0, mix_out=0, out_valid=0.
  - Pipeline valids are cleared; in-flight samples are dropped.
- in_valid during a rst cycle is ignored.
- Tap swap latency: tap change requested at cur_gain=g in IDLE → swap occurs on the (g+2)th accepted sample.

## Test plan
- Dry path: reset, wet_gain=0, dry_gain=8, one in_valid with dry=100 → out_valid exactly 2 cycles later, mix_out=50; no other out_valid pulses.
- Soft start: dry_gain=0, wet_gain=4, tap0=160 constant, continuous in_valid → mix_out 0,10,20,30,40,40,…; fading stays 0 throughout.
- Saturation: dry=255, tap0=255, dry_gain=15, wet_gain=15, stream ≥16 samples → outputs saturate to 255 and never wrap.
- Crossfade: steady IDLE, cur_gain=4, tap0=160, tap1=80, set tap_sel=1 → mix_out 40,40,30,20,10,0 (swap), then 0,5,10,15,20,20.
  - fading is high from after the first sample until FADE_IN reaches gain 4.
  - active_tap changes 0→1 at the swap.
- Gaps and retarget: same as the crossfade scenario but in_valid every 3rd cycle → identical output values, each exactly 2 cycles after its input.
  - Flip tap_sel back to 0 during FADE_IN → FSM re-enters FADE_OUT from the current gain.
- Reset mid-fade: assert rst for 1 cycle during FADE_OUT with 2 samples in flight → next cycle all outputs at reset values; the dropped samples produce no out_valid.
  - Subsequent stream soft-starts from cur_gain=0 on tap 0.

Source files
------------

// File: rtl/delay_tap_crossfade_mixer_if.sv
// Sample bundle between the delay-line bank and the echo mixer.
// The master drives the taps and gains; the slave returns the mix.
interface delay_tap_crossfade_mixer_if #(
  parameter int W      = 8,
  parameter int GAIN_W = 4
);
  logic              in_valid;
  logic [W-1:0]      dry;
  logic [4*W-1:0]    taps;
  logic [1:0]        tap_sel;
  logic [GAIN_W-1:0] dry_gain;
  logic [GAIN_W-1:0] wet_gain;
  logic [W-1:0]      mix_out;
  logic              out_valid;
  logic              fading;
  logic [1:0]        active_tap;

  modport master (
    output in_valid,
    output dry,
    output taps,
    output tap_sel,
    output dry_gain,
    output wet_gain,
    input  mix_out,
    input  out_valid,
    input  fading,
    input  active_tap
  );

  modport slave (
    input  in_valid,
    input  dry,
    input  taps,
    input  tap_sel,
    input  dry_gain,
    input  wet_gain,
    output mix_out,
    output out_valid,
    output fading,
    output active_tap
  );
endinterface

// File: rtl/delay_tap_crossfade_mixer.sv
// Weighted dry/wet echo mixer with click-free tap switching.
// The wet gain ramps to zero, the tap swaps, then it ramps back.
module delay_tap_crossfade_mixer #(
  parameter int W      = 8,
  parameter int GAIN_W = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  delay_tap_crossfade_mixer_if.slave   bus
);

  localparam int PW = W + GAIN_W;
  localparam int SW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    FADE_OUT,
    FADE_IN
  } state_t;

  typedef struct packed {
    logic          vld;
    logic [PW-1:0] pd;
    logic [PW-1:0] pw;
  } stage1_t;

  state_t            state_q;
  state_t            state_d;
  logic [GAIN_W-1:0] gain_q;
  logic [GAIN_W-1:0] gain_d;
  logic [1:0]        tap_q;
  logic [1:0]        tap_d;
  logic              fading_q;

  stage1_t           s1_q;
  logic [PW-1:0]     pd_d;
  logic [PW-1:0]     pw_d;
  logic [W-1:0]      wet_smp;

  logic [SW-1:0]     sum;
  logic [SW-1:0]     shifted;
  logic [W-1:0]      sat;
  logic [W-1:0]      mix_q;
  logic              ov_q;

  function automatic logic [GAIN_W-1:0] step_toward(
    input logic [GAIN_W-1:0] cur,
    input logic [GAIN_W-1:0] tgt
  );
    logic [GAIN_W-1:0] r;
    r = cur;
    if (cur < tgt) begin
      r = cur + GAIN_W'(1);
    end else if (cur > tgt) begin
      r = cur - GAIN_W'(1);
    end
    return r;
  endfunction

  // Pick the wet sample from the tap currently in use.
  always_comb begin
    wet_smp = '0;
    unique case (tap_q)
      2'd0: wet_smp = bus.taps[W-1:0];
      2'd1: wet_smp = bus.taps[2*W-1:W];
      2'd2: wet_smp = bus.taps[3*W-1:2*W];
      2'd3: wet_smp = bus.taps[4*W-1:3*W];
    endcase
  end

  // Gain-ramp FSM; it only advances on accepted samples.
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    tap_d   = tap_q;
    if (bus.in_valid) begin
      unique case (state_q)
        IDLE: begin
          if (bus.tap_sel != tap_q) begin
            state_d = FADE_OUT;
          end else begin
            gain_d = step_toward(gain_q, bus.wet_gain);
          end
        end
        FADE_OUT: begin
          if (gain_q == '0) begin
            tap_d   = bus.tap_sel;
            state_d = FADE_IN;
          end else begin
            gain_d = gain_q - GAIN_W'(1);
          end
        end
        FADE_IN: begin
          if (bus.tap_sel != tap_q) begin
            state_d = FADE_OUT;
          end else if (gain_q == bus.wet_gain) begin
            state_d = IDLE;
          end else begin
            gain_d = step_toward(gain_q, bus.wet_gain);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state, ramp gain, active tap and the fading flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gain_q   <= '0;
      tap_q    <= 2'd0;
      fading_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gain_q   <= gain_d;
      tap_q    <= tap_d;
      fading_q <= (state_d != IDLE);
    end
  end

  // Products use the gain and tap from before this sample's update.
  always_comb begin
    pd_d = PW'(bus.dry) * PW'(bus.dry_gain);
    pw_d = PW'(wet_smp) * PW'(gain_q);
  end

  // Stage 1: register both products for the accepted sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
    end else begin
      s1_q.vld <= bus.in_valid;
      if (bus.in_valid) begin
        s1_q.pd <= pd_d;
        s1_q.pw <= pw_d;
      end
    end
  end

  // Sum, drop the gain fraction bits, clamp to full scale.
  always_comb begin
    sum     = SW'(s1_q.pd) + SW'(s1_q.pw);
    shifted = sum >> GAIN_W;
    sat     = (|shifted[SW-1:W]) ? '1 : shifted[W-1:0];
  end

  // Stage 2: output register, holds its value between samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      mix_q <= '0;
      ov_q  <= 1'b0;
    end else begin
      ov_q <= s1_q.vld;
      if (s1_q.vld) begin
        mix_q <= sat;
      end
    end
  end

  assign bus.mix_out    = mix_q;
  assign bus.out_valid  = ov_q;
  assign bus.fading     = fading_q;
  assign bus.active_tap = tap_q;

endmodule
